// File: rtl/mips_mmio_pkg.sv
// ---------------------------------------------------------------------------
// mips_mmio_pkg
// Shared constants for the MIPS data-side memory responder: MMIO page base,
// register offsets within the page and bit positions of the TX STATUS word.
// ---------------------------------------------------------------------------
package mips_mmio_pkg;

   localparam logic [31:0] MMIO_BASE  = 32'hFFFF_0000;

   // Register offsets inside the 64 KiB MMIO page (word aligned)
   localparam logic [15:0] OFF_LED    = 16'h0000;
   localparam logic [15:0] OFF_CYCLE  = 16'h0004;
   localparam logic [15:0] OFF_TXDATA = 16'h0008;
   localparam logic [15:0] OFF_TXCTL  = 16'h000C;

   // Bit positions in the STATUS word returned by a TXDATA read
   localparam int STATUS_EMPTY = 0;
   localparam int STATUS_FULL  = 1;
   localparam int STATUS_OVF   = 2;

endpackage

// File: rtl/mips_sync_fifo.sv
// ---------------------------------------------------------------------------
// mips_sync_fifo
// Single-clock FIFO with occupancy counter.
//   clk   in          clock
//   rst   in          asynchronous active-high reset (empties the FIFO)
//   push  in          write din; accepted if not full, or if full and popping
//   din   in  [W-1:0] data to write
//   pop   in          remove head; ignored when empty
//   full  out         count == 2**AW
//   empty out         count == 0
//   count out [AW:0]  number of stored entries
//   head  out [W-1:0] oldest entry (meaningless when empty)
// ---------------------------------------------------------------------------
module mips_sync_fifo #(
   parameter int W  = 8,
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count,
   output logic [W-1:0]  head
);

   logic [W-1:0]  mem [2**AW];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(2**AW));
   assign empty   = (count == (AW+1)'(0));
   assign do_pop  = pop & ~empty;
   // A push into a full FIFO still lands when the head leaves in the same cycle
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr];

   // Pointer and occupancy state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= AW'(0);
         rd_ptr <= AW'(0);
         count  <= (AW+1)'(0);
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

endmodule

// File: rtl/mips_data_mem.sv
// ---------------------------------------------------------------------------
// mips_data_mem
// Data-side memory responder for the single-cycle MIPS core: word RAM at
// address 0 plus an MMIO page (LED register, free-running cycle counter,
// byte TX FIFO drained through a valid/ready stream).
//   CLK       in        clock
//   Reset     in        asynchronous active-high reset (RAM not affected)
//   MemWrite  in        store strobe
//   Addr      in  [31:0] byte address, bits [1:0] ignored
//   WriteData in  [31:0] store data
//   ReadData  out [31:0] load data, combinational
//   Leds      out [15:0] LED register
//   TxData    out [7:0]  FIFO head, 0 when empty
//   TxValid   out        FIFO non-empty
//   TxReady   in         consumer takes head when TxValid & TxReady
// ---------------------------------------------------------------------------
module mips_data_mem
   import mips_mmio_pkg::*;
#(
   parameter int          RAM_AW    = 6,
   parameter int          FIFO_AW   = 3,
   parameter logic [31:0] MMIO_BASE = mips_mmio_pkg::MMIO_BASE
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        MemWrite,
   input  logic [31:0] Addr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic [15:0] Leds,
   output logic [7:0]  TxData,
   output logic        TxValid,
   input  logic        TxReady
);

   logic [31:0]      ram [2**RAM_AW];
   logic [31:0]      cycle_cnt;
   logic             ovf;
   logic             ram_sel;
   logic             mmio_sel;
   logic [15:0]      offset;
   logic             push;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [FIFO_AW:0] fifo_count;
   logic [7:0]       fifo_head;

   assign ram_sel  = (Addr[31:RAM_AW+2] == {(30-RAM_AW){1'b0}});
   assign mmio_sel = (Addr[31:16] == MMIO_BASE[31:16]);
   assign offset   = Addr[15:0] & 16'hFFFC;

   assign push     = MemWrite & mmio_sel & (offset == OFF_TXDATA);
   assign pop      = TxValid & TxReady;
   assign TxValid  = ~fifo_empty;
   assign TxData   = TxValid ? fifo_head : 8'h00;

   mips_sync_fifo #(
      .W  (8),
      .AW (FIFO_AW)
   ) u_tx_fifo (
      .clk   (CLK),
      .rst   (Reset),
      .push  (push),
      .din   (WriteData[7:0]),
      .pop   (pop),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count),
      .head  (fifo_head)
   );

   // Word RAM; deliberately outside the reset domain
   always_ff @(posedge CLK) begin
      if (MemWrite && ram_sel) begin
         ram[Addr[RAM_AW+1:2]] <= WriteData;
      end
   end

   // LED register, cycle counter and sticky overflow flag
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         Leds      <= 16'h0000;
         cycle_cnt <= 32'h0000_0000;
         ovf       <= 1'b0;
      end else begin
         if (MemWrite && mmio_sel && (offset == OFF_LED)) begin
            Leds <= WriteData[15:0];
         end
         // A write to CYCLE takes priority over the increment
         if (MemWrite && mmio_sel && (offset == OFF_CYCLE)) begin
            cycle_cnt <= 32'h0000_0000;
         end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
         end
         // Drop happens only when full and the head is not leaving this cycle
         if (push && fifo_full && !pop) begin
            ovf <= 1'b1;
         end else if (MemWrite && mmio_sel && (offset == OFF_TXCTL)) begin
            ovf <= 1'b0;
         end
      end
   end

   // Combinational load path for the single-cycle core
   always_comb begin
      ReadData = 32'h0000_0000;
      if (ram_sel) begin
         ReadData = ram[Addr[RAM_AW+1:2]];
      end else if (mmio_sel) begin
         case (offset)
            OFF_LED:    ReadData = {16'h0000, Leds};
            OFF_CYCLE:  ReadData = cycle_cnt;
            OFF_TXDATA: begin
               ReadData                = 32'h0000_0000;
               ReadData[STATUS_OVF]   = ovf;
               ReadData[STATUS_FULL]  = fifo_full;
               ReadData[STATUS_EMPTY] = fifo_empty;
            end
            OFF_TXCTL:  ReadData = 32'(fifo_count);
            default:    ReadData = 32'h0000_0000;
         endcase
      end else begin
         ReadData = 32'h0000_0000;
      end
   end

endmodule

// File: tb/tb_mips_data_mem.sv
// ---------------------------------------------------------------------------
// tb_mips_data_mem
// Scoreboard bench for mips_data_mem. Each stimulus cycle queues the
// expected port state computed from a queue/array model of the memory map;
// monitors on the falling edge compare the DUT and the TX byte stream.
// ---------------------------------------------------------------------------
module tb_mips_data_mem;

   localparam int DEPTH = 8;
   localparam logic [31:0] A_LED    = 32'hFFFF_0000;
   localparam logic [31:0] A_CYCLE  = 32'hFFFF_0004;
   localparam logic [31:0] A_STATUS = 32'hFFFF_0008;
   localparam logic [31:0] A_TXCTL  = 32'hFFFF_000C;

   logic        CLK = 1'b0;
   logic        Reset = 1'b1;
   logic        MemWrite = 1'b0;
   logic [31:0] Addr = 32'h0;
   logic [31:0] WriteData = 32'h0;
   logic [31:0] ReadData;
   logic [15:0] Leds;
   logic [7:0]  TxData;
   logic        TxValid;
   logic        TxReady = 1'b0;

   always #5 CLK = ~CLK;

   mips_data_mem #(
      .RAM_AW    (6),
      .FIFO_AW   (3),
      .MMIO_BASE (32'hFFFF_0000)
   ) dut (
      .CLK       (CLK),
      .Reset     (Reset),
      .MemWrite  (MemWrite),
      .Addr      (Addr),
      .WriteData (WriteData),
      .ReadData  (ReadData),
      .Leds      (Leds),
      .TxData    (TxData),
      .TxValid   (TxValid),
      .TxReady   (TxReady)
   );

   // ---------------- reference model ----------------
   logic [7:0]  mq[$];
   logic [7:0]  tx_exp[$];
   logic [31:0] ram_m [int];
   logic [15:0] m_leds;
   logic [31:0] m_cycle;
   bit          m_ovf;

   typedef struct {
      string       name;
      bit          rd_known;
      logic [31:0] rd;
      logic [15:0] leds;
      bit          txv;
      logic [7:0]  txd;
   } rec_t;
   rec_t rq[$];
   bit   rd_chk = 1'b0;

   int passed = 0;
   int total  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %08h expected %08h", name, act, exp);
   endtask

   function automatic bit is_ram(input logic [31:0] a);
      return a < 32'h0000_0100;
   endfunction

   function automatic bit is_mmio(input logic [31:0] a);
      return a[31:16] == 16'hFFFF;
   endfunction

   function automatic void model_reset();
      mq.delete();
      tx_exp.delete();
      m_leds  = 16'h0;
      m_cycle = 32'h0;
      m_ovf   = 1'b0;
   endfunction

   function automatic void predict(input logic [31:0] a, output bit known, output logic [31:0] v);
      logic [15:0] off;
      off   = a[15:0] & 16'hFFFC;
      known = 1'b1;
      v     = 32'h0;
      if (is_ram(a)) begin
         if (ram_m.exists(int'(a[7:2]))) v = ram_m[int'(a[7:2])];
         else known = 1'b0;
      end else if (is_mmio(a)) begin
         case (off)
            16'h0000: v = {16'h0, m_leds};
            16'h0004: v = m_cycle;
            16'h0008: v = {29'h0, m_ovf, mq.size() == DEPTH, mq.size() == 0};
            16'h000C: v = mq.size();
            default:  v = 32'h0;
         endcase
      end
   endfunction

   // Effect of one rising edge with the given inputs
   function automatic void model_edge(input bit we, input logic [31:0] a,
                                      input logic [31:0] wd, input bit rdy);
      logic [15:0] off;
      bit          do_pop;
      off    = a[15:0] & 16'hFFFC;
      do_pop = (mq.size() > 0) && rdy;
      if (do_pop) void'(mq.pop_front());
      if (we && is_mmio(a) && off == 16'h0008) begin
         if (mq.size() < DEPTH) begin
            mq.push_back(wd[7:0]);
            tx_exp.push_back(wd[7:0]);
         end else begin
            m_ovf = 1'b1;
         end
      end
      if (we && is_ram(a)) ram_m[int'(a[7:2])] = wd;
      if (we && is_mmio(a) && off == 16'h0000) m_leds = wd[15:0];
      if (we && is_mmio(a) && off == 16'h000C) m_ovf = 1'b0;
      if (we && is_mmio(a) && off == 16'h0004) m_cycle = 32'h0;
      else m_cycle = m_cycle + 32'd1;
   endfunction

   function automatic rec_t mk_rec(input string name, input logic [31:0] a);
      rec_t r;
      r.name = name;
      predict(a, r.rd_known, r.rd);
      r.leds = m_leds;
      r.txv  = mq.size() > 0;
      r.txd  = (mq.size() > 0) ? mq[0] : 8'h00;
      return r;
   endfunction

   // One bus cycle: drive, queue expectation, clock, advance model
   task automatic cyc(input bit we, input logic [31:0] a, input logic [31:0] wd,
                      input bit rdy, input string name);
      MemWrite  = we;
      Addr      = a;
      WriteData = wd;
      TxReady   = rdy;
      rq.push_back(mk_rec(name, a));
      rd_chk = 1'b1;
      @(posedge CLK);
      model_edge(we, a, wd, rdy);
      #1;
      rd_chk = 1'b0;
   endtask

   // Reset asserted between edges; checked before the next edge
   task automatic reset_mid(input string name);
      #1;
      Reset = 1'b1;
      model_reset();
      MemWrite = 1'b0;
      Addr     = A_STATUS;
      TxReady  = 1'b1;
      rq.push_back(mk_rec(name, A_STATUS));
      rd_chk = 1'b1;
      @(posedge CLK);
      #1;
      rd_chk = 1'b0;
      Reset  = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 40 && tx_exp.size() > 0; i++) cyc(1'b0, A_STATUS, 32'h0, 1'b1, name);
      chk({name, "_left"}, tx_exp.size(), 32'd0);
   endtask

   // ---------------- monitors ----------------
   always @(negedge CLK) begin
      if (rd_chk) begin
         if (rq.size() == 0) begin
            total++;
            $display("FAIL scoreboard_underflow: got no record expected one");
         end else begin
            rec_t r;
            r = rq.pop_front();
            if (r.rd_known) chk({r.name, "_rd"}, ReadData, r.rd);
            chk({r.name, "_leds"}, {16'h0, Leds}, {16'h0, r.leds});
            chk({r.name, "_txv"}, {31'h0, TxValid}, {31'h0, r.txv});
            chk({r.name, "_txd"}, {24'h0, TxData}, {24'h0, r.txd});
         end
      end
   end

   always @(negedge CLK) begin
      if (!Reset && TxValid && TxReady) begin
         if (tx_exp.size() == 0) begin
            total++;
            $display("FAIL tx_unexpected: got %02h expected no byte", TxData);
         end else begin
            chk("tx_stream", {24'h0, TxData}, {24'h0, tx_exp.pop_front()});
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      model_reset();
      @(posedge CLK);
      #1;
      // reset state
      Addr = A_STATUS;
      rq.push_back(mk_rec("reset_state", A_STATUS));
      rd_chk = 1'b1;
      @(posedge CLK);
      #1;
      rd_chk = 1'b0;
      Reset  = 1'b0;

      // cycle counter from release
      for (int i = 0; i < 10; i++) cyc(1'b0, A_CYCLE, 32'h0, 1'b0, "cycle_run");
      cyc(1'b0, A_CYCLE, 32'h0, 1'b0, "cycle_10");
      cyc(1'b1, A_CYCLE, 32'h1234_5678, 1'b0, "cycle_wr");
      cyc(1'b0, A_CYCLE, 32'h0, 1'b0, "cycle_after_wr");
      force dut.cycle_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.cycle_cnt;
      m_cycle = 32'hFFFF_FFFF;
      cyc(1'b0, A_CYCLE, 32'h0, 1'b0, "cycle_max");
      cyc(1'b0, A_CYCLE, 32'h0, 1'b0, "cycle_wrap");

      // RAM
      cyc(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, "ram_wr10");
      cyc(1'b0, 32'h0000_0010, 32'h0, 1'b0, "ram_rd10");
      cyc(1'b1, 32'h0000_0014, 32'h1234_5678, 1'b0, "ram_wr14");
      cyc(1'b0, 32'h0000_0014, 32'h0, 1'b0, "ram_rd14");
      cyc(1'b0, 32'h0000_0013, 32'h0, 1'b0, "ram_alias13");
      cyc(1'b1, 32'h0000_00FC, 32'hA5A5_0F0F, 1'b0, "ram_wr_top");
      cyc(1'b0, 32'h0000_00FC, 32'h0, 1'b0, "ram_rd_top");

      // LED
      cyc(1'b1, A_LED, 32'hFFFF_BEEF, 1'b0, "led_wr");
      cyc(1'b0, A_LED, 32'h0, 1'b0, "led_rd");

      // FIFO fill, overflow, clear, drain
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, A_STATUS, 32'h41 + i, 1'b0, "fifo_push");
      cyc(1'b0, A_STATUS, 32'h0, 1'b0, "fifo_full_status");
      cyc(1'b0, A_TXCTL, 32'h0, 1'b0, "fifo_count8");
      cyc(1'b1, A_STATUS, 32'h49, 1'b0, "fifo_push9");
      cyc(1'b0, A_STATUS, 32'h0, 1'b0, "fifo_ovf_status");
      cyc(1'b1, A_TXCTL, 32'h0, 1'b0, "txctl_wr");
      cyc(1'b0, A_STATUS, 32'h0, 1'b0, "fifo_ovf_cleared");
      drain("drain1");
      cyc(1'b0, A_STATUS, 32'h0, 1'b0, "fifo_empty_status");

      // full with simultaneous push/pop
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, A_STATUS, 32'h61 + i, 1'b0, "fifo_push2");
      cyc(1'b1, A_STATUS, 32'h55, 1'b1, "fifo_push_pop_full");
      cyc(1'b0, A_TXCTL, 32'h0, 1'b0, "fifo_count_still8");
      cyc(1'b0, A_STATUS, 32'h0, 1'b0, "fifo_no_ovf");
      drain("drain2");

      // push while empty with TxReady high
      cyc(1'b1, A_STATUS, 32'h77, 1'b1, "push_empty_ready");
      drain("drain3");

      // reset mid-drain
      cyc(1'b1, 32'h0000_0020, 32'hCAFE_F00D, 1'b0, "ram_wr20");
      for (int i = 0; i < 3; i++) cyc(1'b1, A_STATUS, 32'h31 + i, 1'b0, "fifo_push3");
      cyc(1'b0, A_STATUS, 32'h0, 1'b1, "drain_before_reset");
      reset_mid("reset_mid");
      cyc(1'b0, 32'h0000_0020, 32'h0, 1'b0, "ram_after_reset");
      cyc(1'b0, A_CYCLE, 32'h0, 1'b0, "cycle_after_reset");
      cyc(1'b0, A_LED, 32'h0, 1'b0, "led_after_reset");

      // unmapped and unused offsets
      cyc(1'b1, 32'h0000_0000, 32'h1111_2222, 1'b0, "ram_wr0");
      cyc(1'b1, 32'h0001_0000, 32'hFFFF_FFFF, 1'b0, "unmapped_wr");
      cyc(1'b1, 32'hFFFF_0010, 32'hFFFF_FFFF, 1'b0, "unused_wr");
      cyc(1'b0, 32'h0001_0000, 32'h0, 1'b0, "unmapped_rd");
      cyc(1'b0, 32'hFFFF_0010, 32'h0, 1'b0, "unused_rd");
      cyc(1'b0, 32'h0000_0000, 32'h0, 1'b0, "ram0_intact");
      cyc(1'b0, A_STATUS, 32'h0, 1'b0, "status_intact");

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         logic [31:0] a;
         case ($urandom_range(0, 7))
            0, 1:    a = 32'($urandom_range(0, 63)) * 32'd4 + 32'($urandom_range(0, 3));
            2:       a = A_LED;
            3:       a = A_CYCLE;
            4, 5:    a = A_STATUS;
            6:       a = A_TXCTL;
            default: a = ($urandom_range(0, 1) == 0) ? {16'hFFFF, 16'($urandom)} : $urandom;
         endcase
         cyc(($urandom_range(0, 2) == 0) || (a == A_STATUS && $urandom_range(0, 1) == 1),
             a, $urandom, $urandom_range(0, 3) != 0, "rand");
      end
      drain("drain_final");

      chk("records_left", rq.size(), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
